// File: rtl/transposed_fir_hls_div_24s_8ns_16_seq.sv
// Sequential signed-by-unsigned divider: radix-2 restoring on the dividend
// magnitude, then sign fix-up with quotient saturation and divide-by-zero flag.
module transposed_fir_hls_div_24s_8ns_16_seq #(
  parameter int DIVIDEND_WIDTH = 24,
  parameter int DIVISOR_WIDTH  = 8,
  parameter int QUOT_WIDTH     = 16
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DIVIDEND_WIDTH-1:0]     din0,
  input  logic [DIVISOR_WIDTH-1:0]      din1,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [QUOT_WIDTH-1:0]         quot,
  output logic [DIVISOR_WIDTH:0]        rem,
  output logic                          sat,
  output logic                          dbz
);

  localparam int CW = $clog2(DIVIDEND_WIDTH + 1);
  localparam logic [DIVIDEND_WIDTH-1:0] POS_LIM = DIVIDEND_WIDTH'((1 << (QUOT_WIDTH - 1)) - 1);
  localparam logic [DIVIDEND_WIDTH-1:0] NEG_LIM = DIVIDEND_WIDTH'(1 << (QUOT_WIDTH - 1));
  localparam logic [QUOT_WIDTH-1:0]     Q_MAX   = {1'b0, {(QUOT_WIDTH-1){1'b1}}};
  localparam logic [QUOT_WIDTH-1:0]     Q_MIN   = {1'b1, {(QUOT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                    state, state_next;
  logic [CW-1:0]             cnt;
  logic [DIVIDEND_WIDTH-1:0] mag;      // dividend magnitude, becomes quotient magnitude
  logic [DIVISOR_WIDTH-1:0]  part;     // partial remainder, always < divisor
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic                      neg;

  logic [DIVIDEND_WIDTH-1:0] din0_mag;
  logic [DIVISOR_WIDTH:0]    trial;
  logic [DIVISOR_WIDTH-1:0]  diff;
  logic                      fits;
  logic                      last_step;
  logic [QUOT_WIDTH-1:0]     q_lo, quot_fix;
  logic [DIVISOR_WIDTH:0]    rem_ext, rem_fix;
  logic                      sat_fix, dbz_fix;

  // Handshake: in_ready only in IDLE, out_valid only in DONE; a transfer
  // happens on a rising edge where valid and ready are both high.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    din0_mag  = din0[DIVIDEND_WIDTH-1] ? (~din0 + 1'b1) : din0;
    trial     = {part, mag[DIVIDEND_WIDTH-1]};
    fits      = (trial >= {1'b0, divisor});
    // When the trial fits, the difference is below the divisor, so the low bits suffice.
    diff      = trial[DIVISOR_WIDTH-1:0] - divisor;
    last_step = (cnt == CW'(DIVIDEND_WIDTH - 1));
  end

  always_comb begin
    q_lo    = mag[QUOT_WIDTH-1:0];
    rem_ext = {1'b0, part};
    dbz_fix = (divisor == '0);
    sat_fix = 1'b0;
    rem_fix = neg ? (~rem_ext + 1'b1) : rem_ext;
    if (dbz_fix) begin
      quot_fix = neg ? Q_MIN : Q_MAX;
      rem_fix  = '0;
    end else if (neg) begin
      sat_fix  = (mag > NEG_LIM);
      quot_fix = sat_fix ? Q_MIN : (~q_lo + 1'b1);
    end else begin
      sat_fix  = (mag > POS_LIM);
      quot_fix = sat_fix ? Q_MAX : q_lo;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CALC;
      CALC:    if (last_step) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt     <= '0;
      mag     <= '0;
      part    <= '0;
      divisor <= '0;
      neg     <= 1'b0;
      quot    <= '0;
      rem     <= '0;
      sat     <= 1'b0;
      dbz     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mag     <= din0_mag;
          neg     <= din0[DIVIDEND_WIDTH-1];
          divisor <= din1;
          part    <= '0;
          cnt     <= '0;
        end
        CALC: begin
          mag  <= {mag[DIVIDEND_WIDTH-2:0], fits};
          part <= fits ? diff : trial[DIVISOR_WIDTH-1:0];
          cnt  <= cnt + 1'b1;
        end
        FIX: begin
          quot <= quot_fix;
          rem  <= rem_fix;
          sat  <= sat_fix;
          dbz  <= dbz_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_transposed_fir_hls_div_24s_8ns_16_seq.sv
// Directed bench for the sequential divider: latency, signs, saturation,
// divide-by-zero, backpressure and mid-operation reset.
module tb_transposed_fir_hls_div_24s_8ns_16_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] din0 = '0;
  logic [7:0]  din1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quot;
  logic [8:0]  rem;
  logic        sat;
  logic        dbz;

  int checks = 0;
  int errors = 0;

  transposed_fir_hls_div_24s_8ns_16_seq dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .sat(sat), .dbz(dbz)
  );

  always #5 clk = ~clk;

  // Present operands for one edge and count edges until out_valid (bounded).
  task automatic drive_op(input logic [23:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    din0 = a; din1 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 60);
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if ({quot, rem, sat, dbz} !== 27'd0) begin errors++;
      $display("FAIL reset_outputs got quot=%h rem=%h sat=%b dbz=%b want zeros", quot, rem, sat, dbz); end
  endtask

  task automatic test_basic();
    int lat;
    drive_op(24'd1000, 8'd10, lat);
    checks++; if (lat !== 25) begin errors++; $display("FAIL basic_latency got %0d want 25", lat); end
    checks++; if (quot !== 16'd100) begin errors++; $display("FAIL basic_quot got %0d want 100", quot); end
    checks++; if (rem !== 9'd0) begin errors++; $display("FAIL basic_rem got %h want 0", rem); end
    checks++; if ({sat, dbz} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b%b want 00", sat, dbz); end
    release_result();
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++;
      $display("FAIL basic_release got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
    checks++; if (quot !== 16'd100) begin errors++; $display("FAIL basic_hold_idle got %0d want 100", quot); end
  endtask

  task automatic test_signed();
    int lat;
    drive_op(24'hFFFC18, 8'd7, lat);  // -1000 / 7
    checks++; if (quot !== 16'hFF72) begin errors++; $display("FAIL neg_quot got %h want ff72", quot); end
    checks++; if (rem !== 9'h1FA) begin errors++; $display("FAIL neg_rem got %h want 1fa", rem); end
    checks++; if ({sat, dbz} !== 2'b00) begin errors++; $display("FAIL neg_flags got %b%b want 00", sat, dbz); end
    release_result();
    drive_op(24'h7FFFFF, 8'd1, lat);
    checks++; if (quot !== 16'h7FFF) begin errors++; $display("FAIL possat_quot got %h want 7fff", quot); end
    checks++; if ({sat, dbz} !== 2'b10) begin errors++; $display("FAIL possat_flags got %b%b want 10", sat, dbz); end
    checks++; if (rem !== 9'd0) begin errors++; $display("FAIL possat_rem got %h want 0", rem); end
    release_result();
  endtask

  task automatic test_min();
    int lat;
    drive_op(24'h800000, 8'd255, lat);
    checks++; if (lat !== 25) begin errors++; $display("FAIL min_latency got %0d want 25", lat); end
    checks++; if (quot !== 16'h8000) begin errors++; $display("FAIL min_quot got %h want 8000", quot); end
    checks++; if (rem !== 9'h180) begin errors++; $display("FAIL min_rem got %h want 180", rem); end
    checks++; if ({sat, dbz} !== 2'b10) begin errors++; $display("FAIL min_flags got %b%b want 10", sat, dbz); end
    release_result();
  endtask

  task automatic test_dbz();
    int lat;
    drive_op(24'd5, 8'd0, lat);
    checks++; if (lat !== 25) begin errors++; $display("FAIL dbz_latency got %0d want 25", lat); end
    checks++; if ({quot, rem} !== {16'h7FFF, 9'd0}) begin errors++;
      $display("FAIL dbz_pos got quot=%h rem=%h want 7fff 0", quot, rem); end
    checks++; if ({sat, dbz} !== 2'b01) begin errors++; $display("FAIL dbz_pos_flags got %b%b want 01", sat, dbz); end
    release_result();
    drive_op(24'hFFFFFB, 8'd0, lat);
    checks++; if ({quot, rem} !== {16'h8000, 9'd0}) begin errors++;
      $display("FAIL dbz_neg got quot=%h rem=%h want 8000 0", quot, rem); end
    checks++; if ({sat, dbz} !== 2'b01) begin errors++; $display("FAIL dbz_neg_flags got %b%b want 01", sat, dbz); end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    drive_op(24'd100, 8'd3, lat);
    checks++; if ({quot, rem} !== {16'd33, 9'd1}) begin errors++;
      $display("FAIL bp_result got quot=%0d rem=%0d want 33 1", quot, rem); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; din0 = 24'(i * 1234); din1 = 8'(i + 2);
      @(posedge clk); #1;
      if ({out_valid, in_ready, quot, rem, sat, dbz} !== {2'b10, 16'd33, 9'd1, 2'b00}) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++;
      $display("FAIL bp_release got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int bad;
    @(negedge clk);
    din0 = 24'd77; din1 = 8'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++;
      $display("FAIL rst_mid_hs got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
    checks++; if ({quot, rem, sat, dbz} !== 27'd0) begin errors++;
      $display("FAIL rst_mid_outputs got quot=%h rem=%h sat=%b dbz=%b want zeros", quot, rem, sat, dbz); end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_mid_no_valid got %0d cycles want 0", bad); end
    drive_op(24'd1000, 8'd10, lat);
    checks++; if (lat !== 25) begin errors++; $display("FAIL rst_mid_latency got %0d want 25", lat); end
    checks++; if (quot !== 16'd100) begin errors++; $display("FAIL rst_mid_quot got %0d want 100", quot); end
    release_result();
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_basic();
    test_signed();
    test_min();
    test_dbz();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/transposed_fir_hls_div_24s_8ns_16_seq.md
TRANSPOSED_FIR_HLS_DIV_24S_8NS_16_SEQ -- requirements
Module: transposed_fir_hls_div_24s_8ns_16_seq

Interface
REQ-001 SHALL have parameter DIVIDEND_WIDTH, default 24, signed dividend width.
REQ-002 SHALL have parameter DIVISOR_WIDTH, default 8, unsigned divisor width.
REQ-003 SHALL have parameter QUOT_WIDTH, default 16, signed quotient width.
REQ-004 SHALL have port ap_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port ap_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, operands valid.
REQ-007 SHALL have port in_ready, output, 1, block accepts operands.
REQ-008 SHALL have port din0, input, DIVIDEND_WIDTH, signed dividend.
REQ-009 SHALL have port din1, input, DIVISOR_WIDTH, unsigned divisor.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port quot, output, QUOT_WIDTH, signed saturated quotient.
REQ-013 SHALL have port rem, output, DIVISOR_WIDTH+1, signed remainder.
REQ-014 SHALL have port sat, output, 1, quotient was saturated.
REQ-015 SHALL have port dbz, output, 1, divisor was zero.

Function
REQ-016 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-018 SHALL accept operands on an edge with in_valid=1 in IDLE: latch |din0|, sign of din0, din1; clear iteration counter; go to CALC.
REQ-019 SHALL perform one radix-2 restoring step per cycle in CALC on the magnitude: exactly DIVIDEND_WIDTH steps, then go to FIX.
REQ-020 SHALL in FIX apply sign, saturate, register quot/rem/sat/dbz, then go to DONE; out_valid is high DIVIDEND_WIDTH+1 cycles after the accepting edge (25 at default).
REQ-021 SHALL truncate toward zero; rem carries the sign of din0, |rem| < din1, din0 = quot*din1 + rem whenever sat=0.
REQ-022 SHALL saturate quotients above 2^(QUOT_WIDTH-1)-1 to 32767 and below -2^(QUOT_WIDTH-1) to -32768 with sat=1; rem is then the unsaturated remainder.
REQ-023 SHALL handle din1=0 with identical latency: quot=32767 if din0>=0 else -32768, rem=0, dbz=1, sat=0.
REQ-024 SHALL handle din0=-2^(DIVIDEND_WIDTH-1) without overflow (magnitude register DIVIDEND_WIDTH bits unsigned).
REQ-025 SHALL hold quot/rem/sat/dbz stable in DONE until an edge with out_ready=1, then return to IDLE; no new operand accepted in that same cycle.
REQ-026 SHALL ignore in_valid and din0/din1 changes outside IDLE.
REQ-027 SHALL keep quot/rem/sat/dbz at the last registered values while in IDLE and CALC.

Reset
REQ-028 SHALL on ap_rst_n=0, immediately and regardless of clock, enter IDLE and set in_ready=1, out_valid=0, quot=0, rem=0, sat=0, dbz=0, counter=0.
REQ-029 SHALL abandon any division in progress on reset; no out_valid from the aborted operation after reset release.
REQ-030 SHALL resume normal acceptance on the first rising edge after ap_rst_n returns to 1.

Verification
REQ-031 SHALL cover: din0=1000, din1=10 -> quot=100, rem=0, sat=0, dbz=0, out_valid 25 cycles after acceptance.
REQ-032 SHALL cover: din0=-1000, din1=7 -> quot=-142, rem=-6; and din0=8388607, din1=1 -> quot=32767, sat=1, rem=0.
REQ-033 SHALL cover: din0=-8388608, din1=255 -> quot=-32768, sat=1, rem=-128.
REQ-034 SHALL cover: din0=5, din1=0 -> quot=32767, rem=0, dbz=1; din0=-5, din1=0 -> quot=-32768, dbz=1.
REQ-035 SHALL cover backpressure: out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; release -> IDLE next edge.
REQ-036 SHALL cover reset at CALC step 12 -> outputs zero, in_ready=1 asynchronously; next operand 1000/10 yields 100 with normal latency.
